onedconv_buffer_ctrl: RTL and testbench
=======================================

Name: onedconv_buffer_ctrl

Overview:
Sequencer for the 1-D convolution input buffers (DIM weight lanes, DIM ifmap lanes, each a DEPTH-deep shift register).
- Drives the buffer `mode` select and all four per-lane shift-enable vectors.
- Fetches weights from the weight BRAMs and accepts the serial ifmap stream with a valid/ready handshake.
- Issues the compute-phase lane enables toward the PE array.
- Sits between the top-level layer FSM (start/done) and the buffer/PE datapath.

Parameters:
DIM, 16, number of lanes (PE columns)
DEPTH, 17, shift-register depth per lane (DIM+1, includes one zero-pad slot)
RD_LAT, 1, weight BRAM read latency in cycles (1..3)
AW, 5, weight BRAM address width (must satisfy 2^AW >= DEPTH)

Ports:
clk  in  1  clock, posedge; buffers consume enables on the following negedge
rst  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse, begins a load+compute pass; ignored unless IDLE
ifmap_valid  in  1  serial ifmap sample valid
ifmap_ready  out  1  controller accepts ifmap sample
w_rd_en  out  1  weight BRAM read strobe
w_rd_addr  out  AW  weight BRAM address
mode  out  1  0 = input phase, 1 = compute phase
en_ifmap_in  out  DIM  ifmap input-phase lane enables
en_weight_in  out  DIM  weight input-phase lane enables
en_ifmap_ctl  out  DIM  ifmap compute-phase lane enables
en_weight_ctl  out  DIM  weight compute-phase lane enables
compute_valid  out  1  at least one lane shifting in compute phase
busy  out  1  not IDLE
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (rst=0 at posedge), whether idle or mid-pass:
  - state returns to IDLE; counters clear.
  - all outputs go to 0: mode, enables, ifmap_ready, w_rd_en, w_rd_addr, compute_valid, busy, done.
  - a pending RD_LAT pipeline is flushed.
- FSM states: IDLE -> LOAD_W -> LOAD_I -> COMPUTE -> FIN -> IDLE.
- IDLE:
  - start=1 moves to LOAD_W and sets busy the next cycle.
  - start while busy has no effect.
- LOAD_W:
  - w_rd_en=1 for DEPTH consecutive cycles with w_rd_addr = 0..DEPTH-1.
  - en_weight_in = all ones exactly RD_LAT cycles after each strobe, via a registered delay line (DEPTH pulses in total).
  - Move to LOAD_I after the last delayed enable.
  - mode=0.
- LOAD_I:
  - ifmap_ready=1; a beat is accepted when ifmap_valid && ifmap_ready.
  - en_ifmap_in is combinational: one-hot bit `row` on an accepted beat, otherwise 0.
  - Beat counter k runs 0..DEPTH-1; at k=DEPTH-1 on accept, row increments and k wraps to 0.
  - Stalls (valid=0) hold all counters.
  - After row DIM-1 completes, ifmap_ready drops in the same cycle's registered update and the FSM moves to COMPUTE.
  - Total accepted beats = DIM*DEPTH.
- COMPUTE:
  - mode=1; cycle counter t runs 0..DEPTH+DIM-2.
  - Lane i is enabled (both en_ifmap_ctl[i] and en_weight_ctl[i]) iff i <= t < i+DEPTH. This is the systolic skew: each lane shifts exactly DEPTH times.
  - compute_valid = OR of the enables.
  - Move to FIN after t = DEPTH+DIM-2.
- FIN:
  - done=1 for one cycle; mode returns to 0; go to IDLE.
  - start in FIN is ignored.
- Registering: the _in and _ctl vectors are never nonzero in the same cycle. All outputs except en_ifmap_in are registered.
- Widths: counters sized with $clog2(DEPTH+DIM). No wrap beyond the terminal counts.

Optional Feature:
ONEDCONV_CTRL_SKEW_EN
- Defined: the COMPUTE skew is as above; COMPUTE lasts DEPTH+DIM-1 cycles.
- Undefined: all lanes are enabled together for DEPTH cycles (t = 0..DEPTH-1); COMPUTE lasts DEPTH cycles.
- done timing shifts accordingly.

Decomposition:
- Shared package onedconv_pkg holds:
  - state enum (IDLE, LOAD_W, LOAD_I, COMPUTE, FIN);
  - localparam defaults DIM, DEPTH;
  - counter-width function.
- One natural sub-module: onedconv_skew_gen. It takes the cycle counter and returns the DIM-bit compute enable vector, with the skew/no-skew selection inside it.

Test Plan:
- Bench config DIM=4, DEPTH=5, RD_LAT=1. The two skew scenarios assume the default ifmap load (valid=1 except where noted).
- Basic pass, valid always 1, macro defined:
  - w_rd_addr 0..4, en_weight_in=4'hF on the 5 cycles after each strobe;
  - 20 ifmap beats, en_ifmap_in = 1,2,4,8 for 5 beats each;
  - COMPUTE 8 cycles, en_*_ctl = 1,3,7,F,F,E,C,8;
  - done pulses 1 cycle later.
- Handshake stalls:
  - valid toggles 1,0 during LOAD_I -> exactly 20 accepted beats, en_ifmap_in=0 on stall cycles, row advances only after 5 accepts.
  - valid held 0 -> FSM holds in LOAD_I indefinitely.
- Reset mid-pass: rst=0 at COMPUTE t=3 -> next cycle all outputs 0, busy=0; a following start runs a full clean pass.
- start ignored: start pulses while in LOAD_I and in FIN -> no restart, exactly one done per accepted start.
- Macro undefined, bench load as in basic pass: COMPUTE 5 cycles with en_*_ctl=4'hF throughout.
- RD_LAT=3: en_weight_in lags w_rd_en by exactly 3 cycles; LOAD_I entered after the 5th delayed enable.

Source files
------------

// File: rtl/onedconv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onedconv_pkg
// Description : Shared types and sizing helpers for the 1-D conv buffer
//               sequencer.
// Revision    : 1.0
// ============================================================================
package onedconv_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_I  = 3'd2,
        COMPUTE = 3'd3,
        FIN     = 3'd4
    } state_t;

    localparam int c_DIM_DEFAULT   = 16;
    localparam int c_DEPTH_DEFAULT = 17;

    // Wide enough for every phase counter, including the skewed compute span.
    function automatic int cnt_w(input int depth, input int dim);
        return $clog2(depth + dim);
    endfunction

endpackage
`default_nettype wire

// File: rtl/onedconv_skew_gen.sv
`default_nettype none
// ============================================================================
// Module      : onedconv_skew_gen
// Description : Compute-phase lane enables from the compute cycle counter.
//               ONEDCONV_CTRL_SKEW_EN selects the systolic skew.
// Revision    : 1.0
// ============================================================================
module onedconv_skew_gen
    import onedconv_pkg::*;
#(
    parameter int DIM   = c_DIM_DEFAULT,
    parameter int DEPTH = c_DEPTH_DEFAULT,
    parameter int CW    = cnt_w(c_DEPTH_DEFAULT, c_DIM_DEFAULT)
) (
    input  logic            active_i,
    input  logic [CW-1:0]   t_i,
    output logic [DIM-1:0]  en_o
);

    genvar i;
    generate
        for (i = 0; i < DIM; i++) begin : g_lane
`ifdef ONEDCONV_CTRL_SKEW_EN
            // t < i wraps to >= 2^CW - i >= DEPTH, so one compare covers the window.
            logic [CW-1:0] w_rel;
            assign w_rel   = t_i - CW'(i);
            assign en_o[i] = active_i && (w_rel < CW'(DEPTH));
`else
            assign en_o[i] = active_i && (t_i < CW'(DEPTH));
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/onedconv_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : onedconv_buffer_ctrl
// Description : Load/compute sequencer for the 1-D conv input shift buffers.
//               Optional macro ONEDCONV_CTRL_SKEW_EN enables systolic skew.
// Revision    : 1.0
// ============================================================================
module onedconv_buffer_ctrl
    import onedconv_pkg::*;
#(
    parameter int DIM    = c_DIM_DEFAULT,
    parameter int DEPTH  = c_DEPTH_DEFAULT,
    parameter int RD_LAT = 1,
    parameter int AW     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            ifmap_valid,
    output logic            ifmap_ready,
    output logic            w_rd_en,
    output logic [AW-1:0]   w_rd_addr,
    output logic            mode,
    output logic [DIM-1:0]  en_ifmap_in,
    output logic [DIM-1:0]  en_weight_in,
    output logic [DIM-1:0]  en_ifmap_ctl,
    output logic [DIM-1:0]  en_weight_ctl,
    output logic            compute_valid,
    output logic            busy,
    output logic            done
);

    localparam int CW = cnt_w(DEPTH, DIM);
`ifdef ONEDCONV_CTRL_SKEW_EN
    localparam int c_T_LAST = DEPTH + DIM - 2;
`else
    localparam int c_T_LAST = DEPTH - 1;
`endif

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_a_q, cnt_a_d;   // strobes issued / beat k / compute t
    logic [CW-1:0]      cnt_b_q, cnt_b_d;   // delayed weight enables / row
    logic [RD_LAT-1:0]  pipe_q, pipe_d;
    logic               rd_en_q, rd_en_d;
    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic               ready_q, mode_q, busy_q, done_q, cv_q;
    logic [DIM-1:0]     ctl_q;
    logic [DIM-1:0]     w_skew;
    logic               w_accept, w_weight_beat;

    assign w_accept      = ready_q && ifmap_valid;
    assign w_weight_beat = pipe_q[RD_LAT-1];

    assign ifmap_ready   = ready_q;
    assign w_rd_en       = rd_en_q;
    assign w_rd_addr     = rd_addr_q;
    assign mode          = mode_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign compute_valid = cv_q;
    assign en_ifmap_ctl  = ctl_q;
    assign en_weight_ctl = ctl_q;
    assign en_weight_in  = {DIM{w_weight_beat}};
    assign en_ifmap_in   = w_accept ? (DIM'(1) << cnt_b_q) : '0;

    always_comb begin
        state_d   = state_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        pipe_d    = RD_LAT'({pipe_q, rd_en_q});
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_W;
                    rd_en_d = 1'b1;
                    cnt_a_d = CW'(1);
                    cnt_b_d = '0;
                end
            end
            LOAD_W: begin
                if (cnt_a_q < CW'(DEPTH)) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = AW'(cnt_a_q);
                    cnt_a_d   = cnt_a_q + CW'(1);
                end
                if (w_weight_beat) begin
                    if (cnt_b_q == CW'(DEPTH - 1)) begin
                        state_d = LOAD_I;
                        cnt_a_d = '0;
                        cnt_b_d = '0;
                    end else begin
                        cnt_b_d = cnt_b_q + CW'(1);
                    end
                end
            end
            LOAD_I: begin
                if (w_accept) begin
                    if (cnt_a_q == CW'(DEPTH - 1)) begin
                        cnt_a_d = '0;
                        if (cnt_b_q == CW'(DIM - 1)) begin
                            state_d = COMPUTE;
                            cnt_b_d = '0;
                        end else begin
                            cnt_b_d = cnt_b_q + CW'(1);
                        end
                    end else begin
                        cnt_a_d = cnt_a_q + CW'(1);
                    end
                end
            end
            COMPUTE: begin
                if (cnt_a_q == CW'(c_T_LAST)) begin
                    state_d = FIN;
                    cnt_a_d = '0;
                end else begin
                    cnt_a_d = cnt_a_q + CW'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Enables are computed for the upcoming cycle so the lane outputs stay registered.
    onedconv_skew_gen #(
        .DIM   (DIM),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_skew (
        .active_i (state_d == COMPUTE),
        .t_i      (cnt_a_d),
        .en_o     (w_skew)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            pipe_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            ready_q   <= 1'b0;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cv_q      <= 1'b0;
            ctl_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            pipe_q    <= pipe_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            ready_q   <= (state_d == LOAD_I);
            mode_q    <= (state_d == COMPUTE);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == FIN);
            cv_q      <= |w_skew;
            ctl_q     <= w_skew;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onedconv_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_onedconv_buffer_ctrl
// Description : Directed self-checking bench, DIM=4 DEPTH=5, RD_LAT=1 and 3.
// Revision    : 1.0
// ============================================================================
module tb_onedconv_buffer_ctrl;

    localparam int DIM   = 4;
    localparam int DEPTH = 5;
`ifdef ONEDCONV_CTRL_SKEW_EN
    localparam int NCOMP = 8;
`else
    localparam int NCOMP = 5;
`endif
    localparam int C_COMP = 26;              // first COMPUTE cycle after start
    localparam int C_DONE = C_COMP + NCOMP;  // FIN cycle

    logic           clk = 1'b0;
    logic           rst, start, ifmap_valid;
    logic           ifmap_ready, w_rd_en, mode, compute_valid, busy, done;
    logic [2:0]     w_rd_addr;
    logic [DIM-1:0] en_ifmap_in, en_weight_in, en_ifmap_ctl, en_weight_ctl;
    logic           ifmap_ready3, w_rd_en3, mode3, compute_valid3, busy3, done3;
    logic [2:0]     w_rd_addr3;
    logic [DIM-1:0] en_ifmap_in3, en_weight_in3, en_ifmap_ctl3, en_weight_ctl3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    onedconv_buffer_ctrl #(.DIM(DIM), .DEPTH(DEPTH), .RD_LAT(1), .AW(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .ifmap_valid(ifmap_valid),
        .ifmap_ready(ifmap_ready), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .mode(mode), .en_ifmap_in(en_ifmap_in), .en_weight_in(en_weight_in),
        .en_ifmap_ctl(en_ifmap_ctl), .en_weight_ctl(en_weight_ctl),
        .compute_valid(compute_valid), .busy(busy), .done(done)
    );

    onedconv_buffer_ctrl #(.DIM(DIM), .DEPTH(DEPTH), .RD_LAT(3), .AW(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .ifmap_valid(ifmap_valid),
        .ifmap_ready(ifmap_ready3), .w_rd_en(w_rd_en3), .w_rd_addr(w_rd_addr3),
        .mode(mode3), .en_ifmap_in(en_ifmap_in3), .en_weight_in(en_weight_in3),
        .en_ifmap_ctl(en_ifmap_ctl3), .en_weight_ctl(en_weight_ctl3),
        .compute_valid(compute_valid3), .busy(busy3), .done(done3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_ctl(input int t);
`ifdef ONEDCONV_CTRL_SKEW_EN
        case (t)
            0: return 4'h1;
            1: return 4'h3;
            2: return 4'h7;
            3: return 4'hF;
            4: return 4'hF;
            5: return 4'hE;
            6: return 4'hC;
            7: return 4'h8;
            default: return 4'h0;
        endcase
`else
        return (t < 5) ? 4'hF : 4'h0;
`endif
    endfunction

    // Start a pass with valid held high and check cycles 0..ncyc-1 after start.
    task automatic pass_check(input int ncyc);
        logic [3:0] e_ctl;
        @(negedge clk) start = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            e_ctl = (c >= C_COMP && c < C_COMP + NCOMP) ? exp_ctl(c - C_COMP) : 4'h0;
            check($sformatf("w_rd_en@%0d", c), w_rd_en, c <= 4);
            check($sformatf("w_rd_addr@%0d", c), w_rd_addr, (c <= 4) ? c : 0);
            check($sformatf("en_weight_in@%0d", c), en_weight_in, (c >= 1 && c <= 5) ? 4'hF : 4'h0);
            check($sformatf("ifmap_ready@%0d", c), ifmap_ready, c >= 6 && c <= 25);
            check($sformatf("en_ifmap_in@%0d", c), en_ifmap_in,
                  (c >= 6 && c <= 25) ? (4'h1 << ((c - 6) / 5)) : 4'h0);
            check($sformatf("en_ifmap_ctl@%0d", c), en_ifmap_ctl, e_ctl);
            check($sformatf("en_weight_ctl@%0d", c), en_weight_ctl, e_ctl);
            check($sformatf("compute_valid@%0d", c), compute_valid, e_ctl != 4'h0);
            check($sformatf("mode@%0d", c), mode, c >= C_COMP && c < C_COMP + NCOMP);
            check($sformatf("done@%0d", c), done, c == C_DONE);
            check($sformatf("busy@%0d", c), busy, c <= C_DONE);
            if (c <= 10) begin
                check($sformatf("lat3_rd_en@%0d", c), w_rd_en3, c <= 4);
                check($sformatf("lat3_en_weight_in@%0d", c), en_weight_in3,
                      (c >= 3 && c <= 7) ? 4'hF : 4'h0);
                check($sformatf("lat3_ready@%0d", c), ifmap_ready3, c >= 8);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mode"}, mode, 0);
        check({tag, "_ready"}, ifmap_ready, 0);
        check({tag, "_rd_en"}, w_rd_en, 0);
        check({tag, "_rd_addr"}, w_rd_addr, 0);
        check({tag, "_cv"}, compute_valid, 0);
        check({tag, "_enables"}, {en_ifmap_in, en_weight_in, en_ifmap_ctl, en_weight_ctl}, 0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ifmap_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, ifmap_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, cyc, dcnt, n;
        rst = 1'b0; start = 1'b0; ifmap_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic pass (also covers the RD_LAT=3 instance timing)
        pass_check(C_DONE + 2);
        repeat (6) @(negedge clk);

        // Reset at COMPUTE t=3, then a clean pass
        pass_check(C_COMP + 4);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        pass_check(C_DONE + 2);
        repeat (6) @(negedge clk);

        // Valid toggling, plus start pulses in LOAD_I and FIN
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_ready("stall_ready_seen");
        acc = 0; cyc = 0;
        while (ifmap_ready && cyc < 100) begin
            ifmap_valid = (cyc % 2 == 0);
            start = (cyc == 3);
            #1;
            check($sformatf("stall_en_ifmap_in@%0d", cyc), en_ifmap_in,
                  ifmap_valid ? (4'h1 << (acc / 5)) : 4'h0);
            if (ifmap_valid) acc++;
            cyc++;
            @(negedge clk);
        end
        ifmap_valid = 1'b1; start = 1'b0;
        check("stall_accepted_beats", acc, 20);
        check("stall_cycles", cyc, 39);
        dcnt = 0; n = 0;
        while (busy && n < 100) begin
            if (done) begin dcnt++; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("one_done_per_start", dcnt, 1);
        repeat (3) @(negedge clk);
        check("no_restart_busy", busy, 0);
        check("no_restart_done", done, 0);

        // Valid held low: FSM parks in LOAD_I
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_ready("hold_ready_seen");
        ifmap_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("hold_ready", ifmap_ready, 1);
        check("hold_busy", busy, 1);
        check("hold_mode", mode, 0);
        check("hold_en_ifmap_in", en_ifmap_in, 0);
        check("hold_ctl", en_ifmap_ctl, 0);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("hold_reset");
        rst = 1'b1; ifmap_valid = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
